sq_store_queue: RTL and testbench

SQ_STORE_QUEUE -- requirements
Module: sq_store_queue

---
 rtl/sq_store_queue.sv | 140 ++++++++++++++
 tb/tb_sq_store_queue.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sq_store_queue.sv
// Store queue: a circular buffer of 2**LSQ stores with three-wide dispatch and retire,
// out-of-order execute writeback, and byte-granular store-to-load forwarding for two loads.
module sq_store_queue #(
   parameter int LSQ = 3,
   localparam int N  = 1 << LSQ,
   localparam int EW = 69,
   localparam int LW = 36 + LSQ
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [2:0]              i_dispatch,
   output logic [2:0]              o_stall,
   output logic [2:0][LSQ-1:0]     o_tail_pos,
   output logic [N-1:0]            o_load_tail_ready,
   input  logic [2:0]              i_exe_valid,
   input  logic [2:0][EW-1:0]      i_exe_store,
   input  logic [2:0][LSQ-1:0]     i_exe_idx,
   input  logic [1:0][LW-1:0]      i_load_lookup,
   output logic [1:0][36:0]        o_load_forward,
   input  logic [2:0]              i_retire,
   output logic [2:0][EW-1:0]      o_cache_wb,
   output logic [2:0][EW-1:0]      o_sq_head,
   output logic [N-1:0][EW-1:0]    o_sq_display,
   output logic [LSQ-1:0]          o_head_dis,
   output logic [LSQ-1:0]          o_tail_dis,
   output logic [LSQ:0]            o_filled_num_dis,
   output logic [N-1:0][EW-1:0]    o_older_stores_display,
   output logic [N-1:0]            o_older_stores_valid_display
);

   logic [N-1:0][EW-1:0] r_ent, w_ent_nxt;
   logic [LSQ-1:0]       r_head, r_tail;
   logic [LSQ:0]         r_filled, w_free, w_avail;
   logic [2:0]           w_ret, w_disp;
   logic [1:0]           w_ret_cnt, w_disp_cnt;
   logic [N-1:0]         w_rdy;
   logic [1:0][N-1:0]    w_older;
   logic [1:0][3:0]      w_fmask;
   logic [1:0][31:0]     w_fdata;
   logic                 w_unused_addr_lo;

   assign w_unused_addr_lo = ^{i_load_lookup[0][LSQ+5:LSQ+4], i_load_lookup[1][LSQ+5:LSQ+4]};

   always_comb begin
      w_free     = (LSQ+1)'(N) - r_filled;
      o_stall[2] = w_free < (LSQ+1)'(1);
      o_stall[1] = w_free < (LSQ+1)'(2);
      o_stall[0] = w_free < (LSQ+1)'(3);
      o_tail_pos[2] = r_tail;
      o_tail_pos[1] = r_tail + LSQ'(i_dispatch[2]);
      o_tail_pos[0] = r_tail + LSQ'(i_dispatch[2]) + LSQ'(i_dispatch[1]);
      w_ret[0] = i_retire[0] && (r_filled > (LSQ+1)'(0));
      w_ret[1] = w_ret[0] && i_retire[1] && (r_filled > (LSQ+1)'(1));
      w_ret[2] = w_ret[1] && i_retire[2] && (r_filled > (LSQ+1)'(2));
      w_ret_cnt = 2'(w_ret[0]) + 2'(w_ret[1]) + 2'(w_ret[2]);
      // slots freed by this cycle's retires can be refilled on the same edge
      w_avail = w_free + (LSQ+1)'(w_ret_cnt);
      for (int i = 0; i < 3; i++)
         w_disp[i] = i_dispatch[i] && (w_avail >= (LSQ+1)'(3 - i));
      w_disp_cnt = 2'(w_disp[0]) + 2'(w_disp[1]) + 2'(w_disp[2]);
      for (int k = 0; k < 3; k++) begin
         o_sq_head[k]  = r_ent[r_head + LSQ'(k)];
         o_cache_wb[k] = w_ret[k] ? o_sq_head[k] : '0;
      end
   end

   always_comb begin
      w_ent_nxt = r_ent;
      for (int k = 0; k < 3; k++)
         if (w_ret[k]) w_ent_nxt[r_head + LSQ'(k)] = '0;
      for (int i = 0; i < 3; i++)
         if (w_disp[i]) w_ent_nxt[o_tail_pos[i]] = '0;
      for (int i = 0; i < 3; i++)
         if (i_exe_valid[i]) w_ent_nxt[i_exe_idx[i]] = i_exe_store[i];
   end

   always_comb begin
      for (int i = 0; i < N; i++) w_rdy[i] = r_ent[i][68];
   end

   always_comb begin
      for (int t = 0; t < N; t++) begin
         o_load_tail_ready[t] = 1'b1;
         for (int k = 0; k < N; k++)
            if ((LSQ'(k) < LSQ'(t) - r_head) && ((LSQ+1)'(k) < r_filled) &&
                !w_rdy[r_head + LSQ'(k)])
               o_load_tail_ready[t] = 1'b0;
      end
      for (int j = 0; j < 2; j++) begin
         w_older[j] = '0;
         for (int k = 0; k < N; k++)
            if ((LSQ'(k) < i_load_lookup[j][LSQ+3:4] - r_head) && ((LSQ+1)'(k) < r_filled))
               w_older[j][r_head + LSQ'(k)] = 1'b1;
      end
   end

   // Scan oldest to youngest so the youngest matching store wins each byte.
   always_comb begin
      for (int j = 0; j < 2; j++) begin
         w_fmask[j] = '0;
         w_fdata[j] = '0;
         for (int b = 0; b < 4; b++)
            for (int k = 0; k < N; k++)
               if (w_older[j][r_head + LSQ'(k)] &&
                   (r_ent[r_head + LSQ'(k)][67:38] == i_load_lookup[j][LSQ+35:LSQ+6]) &&
                   r_ent[r_head + LSQ'(k)][b] && i_load_lookup[j][b]) begin
                  w_fmask[j][b]         = 1'b1;
                  w_fdata[j][8*b +: 8]  = r_ent[r_head + LSQ'(k)][4 + 8*b +: 8];
               end
         o_load_forward[j] = (|(w_older[j] & ~w_rdy)) ? {1'b1, 36'b0}
                                                      : {1'b0, w_fmask[j], w_fdata[j]};
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++)
         o_older_stores_display[i] = w_older[0][i] ? r_ent[i] : '0;
   end

   assign o_older_stores_valid_display = w_older[0];
   assign o_sq_display                 = r_ent;
   assign o_head_dis                   = r_head;
   assign o_tail_dis                   = r_tail;
   assign o_filled_num_dis             = r_filled;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ent    <= '0;
         r_head   <= '0;
         r_tail   <= '0;
         r_filled <= '0;
      end else begin
         r_ent    <= w_ent_nxt;
         r_head   <= r_head + LSQ'(w_ret_cnt);
         r_tail   <= r_tail + LSQ'(w_disp_cnt);
         r_filled <= r_filled + (LSQ+1)'(w_disp_cnt) - (LSQ+1)'(w_ret_cnt);
      end
   end

endmodule

// File: tb/tb_sq_store_queue.sv
// Directed bench for sq_store_queue: allocation, execute writeback, retire,
// forwarding, full-queue wrap and reset behaviour.
module tb_sq_store_queue;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [2:0]        dispatch, stall, exe_valid, retire;
   logic [2:0][2:0]   tail_pos, exe_idx;
   logic [7:0]        ltr;
   logic [2:0][68:0]  exe_store, cache_wb, sq_head;
   logic [1:0][38:0]  lookup;
   logic [1:0][36:0]  fwd;
   logic [7:0][68:0]  disp, older;
   logic [7:0]        older_v;
   logic [2:0]        head_dis, tail_dis;
   logic [3:0]        filled_dis;

   int n_run  = 0;
   int n_fail = 0;

   logic [68:0] s1, s2, s3;

   always #5 clk = ~clk;

   sq_store_queue #(.LSQ(3)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_dispatch(dispatch), .o_stall(stall), .o_tail_pos(tail_pos),
      .o_load_tail_ready(ltr),
      .i_exe_valid(exe_valid), .i_exe_store(exe_store), .i_exe_idx(exe_idx),
      .i_load_lookup(lookup), .o_load_forward(fwd),
      .i_retire(retire), .o_cache_wb(cache_wb), .o_sq_head(sq_head),
      .o_sq_display(disp), .o_head_dis(head_dis), .o_tail_dis(tail_dis),
      .o_filled_num_dis(filled_dis),
      .o_older_stores_display(older), .o_older_stores_valid_display(older_v)
   );

   function automatic logic [68:0] mk_ent(input logic r, input logic [31:0] a,
                                          input logic [31:0] d, input logic [3:0] u);
      return {r, a, d, u};
   endfunction

   function automatic logic [38:0] mk_lk(input logic [31:0] a, input logic [2:0] tp,
                                         input logic [3:0] u);
      return {a, tp, u};
   endfunction

   task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      s1 = mk_ent(1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 4'b1111);
      s2 = mk_ent(1'b1, 32'h0000_0100, 32'h1122_3344, 4'b1111);
      s3 = mk_ent(1'b1, 32'h0000_0102, 32'hAABB_CCDD, 4'b0110);
      rst_n = 1'b0; dispatch = '0; exe_valid = '0; exe_store = '0; exe_idx = '0;
      retire = '0; lookup = '0;

      #12;
      chk("rst_filled", 69'(filled_dis), 69'(0));
      chk("rst_head",   69'(head_dis),   69'(0));
      chk("rst_tail",   69'(tail_dis),   69'(0));
      chk("rst_stall",  69'(stall),      69'(0));
      chk("rst_ltr",    69'(ltr),        69'(8'hFF));
      chk("rst_fwd0",   69'(fwd[0]),     69'(0));

      @(negedge clk); rst_n = 1'b1; #1;
      chk("rel_stall",  69'(stall),      69'(0));
      chk("rel_filled", 69'(filled_dis), 69'(0));

      dispatch = 3'b010; #1;
      chk("tp1_first",  69'(tail_pos[1]), 69'(0));
      @(negedge clk); dispatch = 3'b001; #1;
      chk("tp0_second", 69'(tail_pos[0]), 69'(1));
      chk("filled_1",   69'(filled_dis),  69'(1));
      @(negedge clk); dispatch = 3'b000; #1;
      chk("filled_2",   69'(filled_dis),  69'(2));
      chk("tail_2",     69'(tail_dis),    69'(2));
      chk("ltr1_notrdy", 69'(ltr[1]),     69'(0));

      exe_valid = 3'b001; exe_idx[0] = 3'd0; exe_store[0] = s1;
      @(negedge clk); exe_valid = '0; #1;
      chk("head0_s1",   sq_head[0],       s1);
      chk("exe_filled", 69'(filled_dis),  69'(2));
      chk("ltr1_rdy",   69'(ltr[1]),      69'(1));
      chk("ltr2_block", 69'(ltr[2]),      69'(0));

      retire = 3'b001; #1;
      chk("wb0_s1",     cache_wb[0],      s1);
      chk("wb1_zero",   cache_wb[1],      69'(0));
      @(negedge clk); retire = '0; #1;
      chk("ret_filled", 69'(filled_dis),  69'(1));
      chk("ret_head",   69'(head_dis),    69'(1));

      lookup[0] = mk_lk(32'h100, 3'd2, 4'b0011);
      lookup[1] = mk_lk(32'h104, 3'd2, 4'b1111);
      #1;
      chk("fwd_stall",  69'(fwd[0]),      69'({1'b1, 36'h0}));
      chk("older_v",    69'(older_v),     69'(8'h02));

      exe_valid = 3'b001; exe_idx[0] = 3'd1; exe_store[0] = s2;
      @(negedge clk); exe_valid = '0; dispatch = 3'b100; #1;
      chk("fwd_lo2",    69'(fwd[0]),      69'({1'b0, 4'b0011, 32'h0000_3344}));
      chk("fwd_other",  69'(fwd[1]),      69'(0));
      chk("tp2_alloc",  69'(tail_pos[2]), 69'(2));
      chk("older_disp", older[1],         s2);

      @(negedge clk); dispatch = '0;
      exe_valid = 3'b001; exe_idx[0] = 3'd2; exe_store[0] = s3;
      @(negedge clk); exe_valid = '0;
      lookup[0] = mk_lk(32'h100, 3'd3, 4'b1111);
      lookup[1] = mk_lk(32'h100, 3'd2, 4'b1111);
      #1;
      chk("fwd_young",  69'(fwd[0]),      69'({1'b0, 4'b1111, 32'h11BB_CC44}));
      chk("fwd_tp2",    69'(fwd[1]),      69'({1'b0, 4'b1111, 32'h1122_3344}));
      chk("ltr_all",    69'(ltr),         69'(8'hFF));

      dispatch = 3'b111; #1;
      chk("stall_f2",   69'(stall),       69'(0));
      @(negedge clk); #1;
      chk("filled_5",   69'(filled_dis),  69'(5));
      chk("stall_f5",   69'(stall),       69'(0));
      @(negedge clk); dispatch = '0; #1;
      chk("filled_8",   69'(filled_dis),  69'(8));
      chk("stall_full", 69'(stall),       69'(3'b111));
      chk("tail_1",     69'(tail_dis),    69'(1));

      dispatch = 3'b111; retire = 3'b111; #1;
      chk("wb0_s2",     cache_wb[0],      s2);
      chk("wb1_s3",     cache_wb[1],      s3);
      @(negedge clk); #1;
      chk("full_f",     69'(filled_dis),  69'(8));
      chk("full_h4",    69'(head_dis),    69'(4));
      chk("full_t4",    69'(tail_dis),    69'(4));
      @(negedge clk); #1;
      chk("full_h7",    69'(head_dis),    69'(7));
      chk("tp1_wrap",   69'(tail_pos[1]), 69'(0));
      chk("tp0_wrap",   69'(tail_pos[0]), 69'(1));
      @(negedge clk); dispatch = '0; retire = 3'b001; #1;
      chk("wrap_head",  69'(head_dis),    69'(2));
      chk("wrap_tail",  69'(tail_dis),    69'(2));
      chk("wrap_fill",  69'(filled_dis),  69'(8));
      @(negedge clk); retire = '0; #1;
      chk("filled_7",   69'(filled_dis),  69'(7));
      chk("stall_f7",   69'(stall),       69'(3'b011));

      retire = 3'b001; rst_n = 1'b0; #1;
      chk("mid_rst_wb", cache_wb[0],      69'(0));
      chk("mid_rst_f",  69'(filled_dis),  69'(0));
      chk("mid_rst_h",  69'(head_dis),    69'(0));
      chk("mid_rst_ltr", 69'(ltr),        69'(8'hFF));
      @(negedge clk); retire = '0; rst_n = 1'b1; #1;

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
